// File: rtl/uart_frame_rcvr.sv
// Parametrised UART receiver: start/data/parity/stop deserialiser feeding a
// show-ahead FIFO, with one-cycle error pulses and RTS from FIFO occupancy.
module uart_frame_rcvr #(
  parameter int CLKS_PER_BAUD = 54,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_rts,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BAUD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam int BIT_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s, rx_prev;
  logic [1:0]           warm;
  logic                 fall_edge, baud_tick, frame_done, last_data, last_stop;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt, stop_bad, par_bit, par_exp, par_bad;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend_valid, pend_ferr, pend_perr;
  logic [DATA_BITS-1:0] pend_data;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [FC_W-1:0]      count_nxt;
  logic                 good, full, pop, push;

  // rx_prev only follows rx_s once the synchroniser holds real line values,
  // so a line already low at reset release never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b0;
      warm    <= 2'd0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      if (warm != 2'd2) warm <= warm + 2'd1;
      rx_prev <= (warm == 2'd2) ? rx_s : 1'b0;
    end
  end

  assign fall_edge = rx_prev & ~rx_s;
  assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign par_exp   = (^shreg) ^ (PARITY == 1);
  assign par_bad   = (PARITY != 0) && (par_bit != par_exp);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (fall_edge) state_nxt = S_START;
      S_START:  if (baud_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (baud_tick && last_data) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (baud_tick) state_nxt = S_STOP;
      S_STOP:   if (frame_done) state_nxt = (stop_bad || !rx_s) ? S_BREAK : S_IDLE;
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The start bit is sampled half a bit in; every later sample is a full bit apart.
  always_comb begin
    baud_tick  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_START:                 baud_tick = (cnt == CNT_W'(CLKS_PER_BAUD/2 - 1));
      S_DATA, S_PARITY, S_STOP: baud_tick = (cnt == CNT_W'(CLKS_PER_BAUD - 1));
      default:                 baud_tick = 1'b0;
    endcase
    frame_done = (state == S_STOP) && baud_tick && last_stop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      stop_bad   <= 1'b0;
      par_bit    <= 1'b0;
      shreg      <= '0;
      pend_valid <= 1'b0;
      pend_ferr  <= 1'b0;
      pend_perr  <= 1'b0;
      pend_data  <= '0;
    end else begin
      cnt <= (state == S_IDLE || state == S_BREAK || baud_tick) ? '0 : cnt + CNT_W'(1);
      if (state == S_START) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (baud_tick) begin
        unique case (state)
          S_DATA: begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
          S_PARITY: par_bit <= rx_s;
          S_STOP: begin
            stop_cnt <= stop_cnt + 1'b1;
            stop_bad <= stop_bad | ~rx_s;
          end
          default: ;
        endcase
      end
      // Frame results are judged one cycle after the last stop sample.
      pend_valid <= frame_done;
      pend_ferr  <= stop_bad | ~rx_s;
      pend_perr  <= par_bad;
      pend_data  <= shreg;
    end
  end

  assign good     = pend_valid & ~pend_ferr & ~pend_perr;
  assign full     = (fifo_count == FC_W'(FIFO_DEPTH));
  assign rd_valid = (fifo_count != '0);
  assign pop      = rd_en & rd_valid;
  assign push     = good & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + FC_W'(1);
    else if (pop && !push) count_nxt = fifo_count - FC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= pend_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      uart_rts    <= 1'b1;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count  <= count_nxt;
      uart_rts    <= (count_nxt <= FC_W'(FIFO_DEPTH - 2));
      framing_err <= pend_valid & pend_ferr;
      parity_err  <= pend_valid & ~pend_ferr & pend_perr;
      overrun_err <= good & full & ~rd_en;
    end
  end

endmodule
